// File: rtl/spi_accel_target_pkg.sv
// spi_accel_target_pkg: register map, command-byte fields, FSM states and register read mux
// shared by the SPI accelerometer target.
package spi_accel_target_pkg;
    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_TEMP_CFG = 6'h1F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_CTRL4    = 6'h23;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H  = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L  = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H  = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L  = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H  = 6'h2D;
    localparam int RW_BIT = 7;
    localparam int MS_BIT = 6;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RD, ST_WR} state_t;

    // OUT_* live at 0x28..0x2D, so the low three address bits index the sample bytes directly.
    function automatic logic [7:0] read_reg(input logic [5:0] a, input logic [7:0] who, temp, c1, c4,
                                            input logic [5:0][7:0] outs);
        case (a)
            ADDR_WHO_AM_I: read_reg = who;
            ADDR_TEMP_CFG: read_reg = temp;
            ADDR_CTRL1:    read_reg = c1;
            ADDR_CTRL4:    read_reg = c4;
            ADDR_OUT_X_L, ADDR_OUT_X_H, ADDR_OUT_Y_L,
            ADDR_OUT_Y_H, ADDR_OUT_Z_L, ADDR_OUT_Z_H: read_reg = outs[a[2:0]];
            default:       read_reg = 8'h00;
        endcase
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous pin with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES:0] q;

    always_ff @(posedge clk_in)
        if (rst) q <= {(STAGES + 1){RST_VAL}};
        else     q <= {q[STAGES-1:0], din};

    assign rise = q[STAGES-1] & ~q[STAGES];
    assign fall = ~q[STAGES-1] & q[STAGES];
endmodule

// File: rtl/spi_accel_target.sv
// spi_accel_target: SPI mode-3 target emulating a 3-axis accelerometer register file.
// Define SPI_TARGET_PATTERN_GEN_EN to replace acc_* with an incrementing OUT_X_L test pattern.
module spi_accel_target #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
    parameter logic [7:0] CTRL1_RST    = 8'h07,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [15:0] acc_x,
    input  logic [15:0] acc_y,
    input  logic [15:0] acc_z,
    input  logic        acc_valid,
    output logic [7:0]  ctrl_reg1,
    output logic [7:0]  ctrl_reg4,
    output logic [7:0]  temp_cfg,
    output logic        xfer_done
);
    import spi_accel_target_pkg::*;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_q;
    state_t state, state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] rx;
    logic [7:0] rx_byte, tx, rd_cmd, rd_step;
    logic [5:0] addr, addr_step;
    logic ms, byte_end, commit;
    logic [5:0][7:0] out_regs;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk_in(clk_in), .rst(rst), .din(spi_sclk), .rise(sclk_rise), .fall(sclk_fall));

    // Reset low so a CS already asserted across reset release never yields a falling edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk_in(clk_in), .rst(rst), .din(spi_cs_n), .rise(cs_rise), .fall(cs_fall));

    always_ff @(posedge clk_in)
        if (rst) mosi_q <= '0;
        else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};

    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign rx_byte   = {rx, mosi_s};
    assign byte_end  = sclk_rise && bit_cnt == 3'd7;
    assign addr_step = ms ? addr + 6'd1 : addr;
    assign commit    = cs_rise && state != ST_IDLE;
    assign rd_cmd    = read_reg(rx_byte[5:0], WHO_AM_I_VAL, temp_cfg, ctrl_reg1, ctrl_reg4, out_regs);
    assign rd_step   = read_reg(addr_step, WHO_AM_I_VAL, temp_cfg, ctrl_reg1, ctrl_reg4, out_regs);

    always_ff @(posedge clk_in)
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (cs_rise)
            state_nxt = ST_IDLE;
        else if (state == ST_IDLE && cs_fall)
            state_nxt = ST_CMD;
        else if (state == ST_CMD && byte_end)
            state_nxt = rx_byte[RW_BIT] ? ST_RD : ST_WR;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            addr        <= '0;
            ms          <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            xfer_done   <= 1'b0;
            temp_cfg    <= '0;
            ctrl_reg1   <= CTRL1_RST;
            ctrl_reg4   <= '0;
        end else begin
            xfer_done <= commit;
            if (cs_rise || (state == ST_IDLE && cs_fall)) begin
                bit_cnt     <= '0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else if (state != ST_IDLE) begin
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx      <= rx_byte[6:0];
                end
                if (state == ST_CMD && byte_end) begin
                    addr <= rx_byte[5:0];
                    ms   <= rx_byte[MS_BIT];
                    if (rx_byte[RW_BIT]) begin
                        tx          <= rd_cmd;
                        spi_miso_oe <= 1'b1;
                    end
                end
                // Next byte is prefetched on the last rise so the following fall can drive its MSB.
                if (state == ST_RD && byte_end) begin
                    addr <= addr_step;
                    tx   <= rd_step;
                end
                if (state == ST_RD && sclk_fall) begin
                    spi_miso <= tx[7];
                    tx       <= {tx[6:0], 1'b0};
                end
                if (state == ST_WR && byte_end) begin
                    addr <= addr_step;
                    if (addr == ADDR_TEMP_CFG) temp_cfg  <= rx_byte;
                    if (addr == ADDR_CTRL1)    ctrl_reg1 <= rx_byte;
                    if (addr == ADDR_CTRL4)    ctrl_reg4 <= rx_byte;
                end
            end
        end
    end

`ifdef SPI_TARGET_PATTERN_GEN_EN
    logic rd_x_l, load_x_l;

    assign load_x_l = (state == ST_CMD && byte_end && rx_byte[RW_BIT] && rx_byte[5:0] == ADDR_OUT_X_L) ||
                      (state == ST_RD && byte_end && addr_step == ADDR_OUT_X_L);

    always_ff @(posedge clk_in)
        if (rst) begin
            out_regs <= {40'h0, 8'h9A};
            rd_x_l   <= 1'b0;
        end else begin
            if (commit && rd_x_l) out_regs[0] <= out_regs[0] + 8'h20;
            rd_x_l <= !commit && (rd_x_l || load_x_l);
        end
`else
    logic [5:0][7:0] pend;
    logic pend_valid;

    // Block-data-update: samples arriving mid-transaction are parked until CS releases.
    always_ff @(posedge clk_in)
        if (rst) begin
            out_regs   <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (commit) begin
            if (acc_valid || pend_valid) out_regs <= acc_valid ? {acc_z, acc_y, acc_x} : pend;
            pend_valid <= 1'b0;
        end else if (acc_valid) begin
            if (state == ST_IDLE) out_regs <= {acc_z, acc_y, acc_x};
            else begin
                pend       <= {acc_z, acc_y, acc_x};
                pend_valid <= 1'b1;
            end
        end
`endif
endmodule

// File: tb/tb_spi_accel_target.sv
// tb_spi_accel_target: directed SPI mode-3 transactions against spi_accel_target with hand-computed results.
module tb_spi_accel_target;
    logic clk_in = 1'b0, rst = 1'b1;
    logic spi_sclk = 1'b1, spi_cs_n = 1'b1, spi_mosi = 1'b0, acc_valid = 1'b0;
    logic [15:0] acc_x = '0, acc_y = '0, acc_z = '0;
    logic spi_miso, spi_miso_oe, xfer_done;
    logic [7:0] ctrl_reg1, ctrl_reg4, temp_cfg;
    int n_checks = 0, n_errors = 0, n_done = 0, done_ref;
    logic [7:0] rd;
    logic oe_any, oe_all;

    spi_accel_target dut (
        .clk_in(clk_in), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .acc_valid(acc_valid), .ctrl_reg1(ctrl_reg1), .ctrl_reg4(ctrl_reg4), .temp_cfg(temp_cfg),
        .xfer_done(xfer_done));

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (xfer_done) n_done++;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic cs_low;
        spi_cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high;
        tick(8);
        spi_cs_n = 1'b1;
        tick(8);
    endtask

    task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        acc_x = x; acc_y = y; acc_z = z; acc_valid = 1'b1;
        tick(1);
        acc_valid = 1'b0;
    endtask

    // Eight clk_in per SCLK phase; MISO is sampled at the end of the low phase, just before the rise.
    task automatic xfer_bits(input logic [7:0] mo, input int nb, output logic [7:0] mi,
                             output logic any, output logic all);
        mi = '0; any = 1'b0; all = 1'b1;
        for (int i = 7; i > 7 - nb; i--) begin
            spi_sclk = 1'b0;
            spi_mosi = mo[i];
            tick(8);
            mi[i] = spi_miso;
            any |= spi_miso_oe;
            all &= spi_miso_oe;
            spi_sclk = 1'b1;
            tick(8);
        end
    endtask

    task automatic read_seq(input string tag, input logic [7:0] cmd, input int n, input logic [23:0] exp);
        cs_low;
        xfer_bits(cmd, 8, rd, oe_any, oe_all);
        check({tag, " cmd oe"}, {15'd0, oe_any}, 16'd0);
        for (int k = 0; k < n; k++) begin
            xfer_bits(8'h00, 8, rd, oe_any, oe_all);
            check($sformatf("%s byte%0d", tag, k), {8'd0, rd}, {8'd0, exp[23 - 8 * k -: 8]});
            check($sformatf("%s oe%0d", tag, k), {15'd0, oe_all}, 16'd1);
        end
        cs_high;
        check({tag, " oe idle"}, {15'd0, spi_miso_oe}, 16'd0);
    endtask

    task automatic write_seq(input string tag, input logic [7:0] cmd, input int n, input logic [15:0] data);
        logic seen;
        cs_low;
        xfer_bits(cmd, 8, rd, oe_any, oe_all);
        seen = oe_any;
        for (int k = 0; k < n; k++) begin
            xfer_bits(data[15 - 8 * k -: 8], 8, rd, oe_any, oe_all);
            seen |= oe_any;
        end
        check({tag, " oe"}, {15'd0, seen}, 16'd0);
    endtask

    initial begin
        tick(5);
        check("rst miso", {15'd0, spi_miso}, 16'd0);
        check("rst oe", {15'd0, spi_miso_oe}, 16'd0);
        rst = 1'b0;
        tick(4);
        check("rst ctrl1", {8'd0, ctrl_reg1}, 16'h0007);
        check("rst ctrl4", {8'd0, ctrl_reg4}, 16'h0000);
        check("rst temp", {8'd0, temp_cfg}, 16'h0000);
        check("rst done", {15'd0, xfer_done}, 16'd0);

        done_ref = n_done;
        read_seq("whoami", 8'h8F, 1, 24'h330000);
        check("whoami done", 16'(n_done - done_ref), 16'd1);

        write_seq("wr ctrl1", 8'h20, 1, 16'h7700);
        check("ctrl1 77", {8'd0, ctrl_reg1}, 16'h0077);
        cs_high;
        read_seq("rd ctrl1", 8'hA0, 1, 24'h770000);

        write_seq("wr multi", 8'h5F, 2, 16'hA53C);
        cs_high;
        check("temp a5", {8'd0, temp_cfg}, 16'h00A5);
        check("ctrl1 3c", {8'd0, ctrl_reg1}, 16'h003C);
        read_seq("rd multi", 8'hDF, 2, 24'hA53C00);

        read_seq("wrap", 8'hFF, 2, 24'h000000);

        write_seq("wr ro", 8'h0F, 1, 16'h5500);
        cs_high;
        read_seq("ro whoami", 8'h8F, 1, 24'h330000);

        write_seq("wr ctrl4", 8'h23, 1, 16'h8100);
        cs_high;
        check("ctrl4 81", {8'd0, ctrl_reg4}, 16'h0081);

        done_ref = n_done;
        cs_low;
        xfer_bits(8'h23, 8, rd, oe_any, oe_all);
        xfer_bits(8'h00, 5, rd, oe_any, oe_all);
        cs_high;
        check("partial ctrl4", {8'd0, ctrl_reg4}, 16'h0081);
        check("partial done", 16'(n_done - done_ref), 16'd1);
        read_seq("after partial", 8'h8F, 1, 24'h330000);

`ifdef SPI_TARGET_PATTERN_GEN_EN
        read_seq("pat0", 8'hE8, 1, 24'h9A0000);
        read_seq("pat1", 8'hE8, 1, 24'hBA0000);
        read_seq("pat2", 8'hE8, 1, 24'hDA0000);
`else
        strobe(16'h1234, 16'h5678, 16'h9ABC);
        tick(2);
        read_seq("acc x", 8'hE8, 2, 24'h341200);
        read_seq("acc ms0", 8'hA8, 3, 24'h343434);
        read_seq("acc yz", 8'hEA, 3, 24'h7856BC);

        cs_low;
        xfer_bits(8'hA8, 8, rd, oe_any, oe_all);
        strobe(16'h1111, 16'h0, 16'h0);
        strobe(16'h2222, 16'h0, 16'h0);
        xfer_bits(8'h00, 8, rd, oe_any, oe_all);
        check("bdu hold", {8'd0, rd}, 16'h0034);
        cs_high;
        read_seq("bdu commit", 8'hA8, 1, 24'h220000);

        cs_low;
        xfer_bits(8'hA8, 8, rd, oe_any, oe_all);
        strobe(16'h3333, 16'h0, 16'h0);
        xfer_bits(8'h00, 8, rd, oe_any, oe_all);
        tick(8);
        spi_cs_n = 1'b1;
        tick(2);
        strobe(16'h4444, 16'h0, 16'h0);
        tick(8);
        read_seq("bdu coincident", 8'hA8, 1, 24'h440000);
`endif

        cs_low;
        xfer_bits(8'h20, 8, rd, oe_any, oe_all);
        xfer_bits(8'hFF, 4, rd, oe_any, oe_all);
        rst = 1'b1;
        tick(3);
        check("midrst ctrl1", {8'd0, ctrl_reg1}, 16'h0007);
        check("midrst temp", {8'd0, temp_cfg}, 16'h0000);
        rst = 1'b0;
        tick(4);
        done_ref = n_done;
        xfer_bits(8'hFF, 4, rd, oe_any, oe_all);
        check("midrst oe", {15'd0, oe_any}, 16'd0);
        cs_high;
        check("midrst ctrl1 kept", {8'd0, ctrl_reg1}, 16'h0007);
        check("midrst no done", 16'(n_done - done_ref), 16'd0);
        read_seq("post rst", 8'hA0, 1, 24'h070000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
